// File: rtl/arbiter_pkg.sv
// Shared types and constants for the back-end bank-group arbitration path.
// Used by the group requesters and the group arbiter.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    BURST   = 2'd2,
    RELEASE = 2'd3
  } req_state_t;

  localparam logic [1:0] GROUP_A = 2'd0;
  localparam logic [1:0] GROUP_B = 2'd1;
  localparam logic [1:0] GROUP_C = 2'd2;
  localparam logic [1:0] GROUP_D = 2'd3;

  function automatic int bcnt_w(input int max_b);
    return $clog2(max_b + 1);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous power-of-two FIFO with occupancy count.
// Push when full and pop when empty are ignored.
module cmd_fifo #(
  parameter int CMD_W = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] wdata,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_C = DEPTH[AW:0];

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_cnt == FULL_C);
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign rdata  = r_mem[r_rp];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push}
                     - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= wdata;
  end

endmodule

// File: rtl/bank_group_requester.sv
// Per-bank-group requester: queues commands, requests the group
// arbiter and issues up to MAX_BURSTS commands per grant.
module bank_group_requester
  import arbiter_pkg::*;
#(
  parameter int CMD_W      = 32,
  parameter int DEPTH      = 8,
  parameter int MAX_BURSTS = 4,
  localparam int BW = bcnt_w(MAX_BURSTS),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] in_cmd,
  output logic             req,
  input  logic             start,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CMD_W-1:0] out_cmd,
  output logic [BW-1:0]    burst_cnt
);

  localparam logic [BW-1:0] CNT_LAST = BW'(MAX_BURSTS - 1);
  localparam logic [AW:0]   ONE      = {{AW{1'b0}}, 1'b1};

  req_state_t    r_state;
  req_state_t    w_next;
  logic          r_rdy;
  logic [BW-1:0] r_cnt;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic          w_push;
  logic          w_pop;
  logic          w_grant;
  logic          w_rel;

  cmd_fifo #(
    .CMD_W(CMD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (w_push),
    .pop  (w_pop),
    .wdata(in_cmd),
    .rdata(out_cmd),
    .full (w_full),
    .empty(w_empty),
    .count(w_count)
  );

  assign in_ready  = r_rdy && !w_full;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign burst_cnt = r_cnt;
  assign w_grant   = (r_state == REQUEST) ||
                     (r_state == BURST);
  // Last pop of the grant: quota reached or queue drained.
  assign w_rel = w_pop && ((r_cnt == CNT_LAST) ||
                 ((w_count == ONE) && !w_push));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (!w_empty || w_push) w_next = REQUEST;
      REQUEST:
        if (w_rel)      w_next = RELEASE;
        else if (start) w_next = BURST;
      BURST:
        if (w_rel)       w_next = RELEASE;
        else if (!start) w_next = REQUEST;
      RELEASE:
        w_next = w_empty ? IDLE : REQUEST;
      default:
        w_next = IDLE;
    endcase
  end

  always_comb begin
    req       = w_grant;
    done      = (r_state == RELEASE);
    out_valid = w_grant && start && !w_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((w_next == RELEASE) ||
                 ((r_state == BURST) && !start)) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bank_group_requester.sv
// Directed and random stimulus for bank_group_requester against
// a queue-based model of the grant/burst/release protocol.
module tb_bank_group_requester;

  localparam int DEPTH = 8;
  localparam int MAXB  = 4;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_BUR  = 2;
  localparam int P_REL  = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_cmd;
  logic        req;
  logic        start;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_cmd;
  logic [2:0]  burst_cnt;

  int checks;
  int failures;

  logic [31:0] m_q[$];
  int          ph;
  int          m_cnt;
  bit          m_rdy;

  bank_group_requester #(
    .CMD_W(32),
    .DEPTH(DEPTH),
    .MAX_BURSTS(MAXB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cmd   (in_cmd),
    .req      (req),
    .start    (start),
    .done     (done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cmd  (out_cmd),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    ph    = P_IDLE;
    m_cnt = 0;
    m_rdy = 0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovalid"}, out_valid, 0);
    chk({tag, "_bcnt"}, burst_cnt, 0);
    chk({tag, "_iready"}, in_ready, 0);
  endtask

  // One clock cycle: drive, check against model, advance model.
  task automatic cyc(input bit iv, input bit st, input bit ordy);
    logic [31:0] cmd;
    bit e_req, e_done, e_ov, e_ir, push, pop, drained;
    int nc, sz, nph;
    cmd = $urandom;
    in_valid  = iv;
    in_cmd    = cmd;
    start     = st;
    out_ready = ordy;
    #2;
    sz     = m_q.size();
    e_req  = (ph == P_REQ) || (ph == P_BUR);
    e_done = (ph == P_REL);
    e_ov   = e_req && st && (sz > 0);
    e_ir   = m_rdy && (sz < DEPTH);
    chk("req", req, e_req);
    chk("done", done, e_done);
    chk("out_valid", out_valid, e_ov);
    chk("in_ready", in_ready, e_ir);
    chk("burst_cnt", burst_cnt, m_cnt);
    if (sz > 0) chk("out_cmd", out_cmd, m_q[0]);
    push    = iv && e_ir;
    pop     = e_ov && ordy;
    drained = pop && (sz == 1) && !push;
    nc      = m_cnt + int'(pop);
    nph     = ph;
    case (ph)
      P_IDLE: if (sz > 0 || push) nph = P_REQ;
      P_REQ, P_BUR: begin
        if (pop && (nc == MAXB || drained)) begin
          nph = P_REL;
          nc  = 0;
        end else if (ph == P_BUR && !st) begin
          nph = P_REQ;
          nc  = 0;
        end else if (ph == P_REQ && st) begin
          nph = P_BUR;
        end
      end
      default: nph = (sz > 0) ? P_REQ : P_IDLE;
    endcase
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(cmd);
    ph    = nph;
    m_cnt = nc;
    @(posedge clk);
    #1;
    m_rdy = 1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clk       = 0;
    rst_n     = 0;
    in_valid  = 0;
    in_cmd    = '0;
    start     = 0;
    out_ready = 0;
    model_reset();
    #1;
    chk_cleared("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    cyc(0, 0, 0);

    // single command, start high throughout
    cyc(1, 1, 1);
    repeat (4) cyc(0, 1, 1);

    // six commands, two grants of 4 and 2
    repeat (6) cyc(1, 0, 1);
    repeat (10) cyc(0, 1, 1);

    // fill to full, then pop with a blocked push
    repeat (9) cyc(1, 0, 1);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    repeat (14) cyc(0, 1, 1);

    // preemption after two pops, then a fresh grant
    repeat (7) cyc(1, 0, 1);
    repeat (2) cyc(0, 1, 1);
    repeat (2) cyc(0, 0, 1);
    repeat (8) cyc(0, 1, 1);
    repeat (4) cyc(0, 1, 1);

    // out_ready stalls mid-burst
    repeat (5) cyc(1, 0, 1);
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    repeat (8) cyc(0, 1, 1);

    // random traffic
    for (int i = 0; i < 600; i++)
      cyc(bit'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0);
    repeat (20) cyc(0, 1, 1);

    // asynchronous reset mid-burst
    repeat (5) cyc(1, 0, 1);
    repeat (2) cyc(0, 1, 1);
    #2;
    rst_n = 0;
    #1;
    chk_cleared("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc(0, 1, 1);
    repeat (3) cyc(0, 1, 1);
    cyc(1, 1, 1);
    repeat (4) cyc(0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bank_group_requester.md
Name: bank_group_requester

Overview:
- Request side of the bank-group arbitration handshake, one instance per bank group (A..D) in the back-end arbiter.
- Buffers scheduled commands for its group and raises req to the group arbiter.
- While the arbiter holds start high, it issues up to MAX_BURSTS commands to the shared command bus, then pulses done to release the grant.

Parameters:
- CMD_W, 32, width of one scheduled command word.
- DEPTH, 8, command FIFO depth; power of two, at least 2.
- MAX_BURSTS, 4, maximum commands issued per grant; range 1..DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command from bank scheduler is valid.
- in_ready  out  1  FIFO can accept a command.
- in_cmd  in  CMD_W  command word.
- req  out  1  request to group arbiter.
- start  in  1  grant from arbiter; combinational from the arbiter state.
- done  out  1  grant release, one-cycle pulse.
- out_valid  out  1  command presented to command bus.
- out_ready  in  1  command bus accepts.
- out_cmd  out  CMD_W  FIFO head.
- burst_cnt  out  $clog2(MAX_BURSTS+1)  commands issued in the current grant.

Behaviour:
- Reset is asynchronous and active-low. All outputs and state clear immediately on rst_n low:
  - state=IDLE; FIFO empty; burst_cnt=0.
  - req=0, done=0, out_valid=0; in_ready=1 after the first edge with rst_n high.
- FIFO:
  - push on in_valid && in_ready.
  - in_ready = !full. A full FIFO does not accept a push even when a pop occurs in the same cycle.
  - Simultaneous push and pop with 0 < occupancy < DEPTH leaves occupancy unchanged.
  - out_cmd is always the FIFO head; it is undefined when the FIFO is empty.
- Pop rule: pop = out_valid && out_ready; burst_cnt increments on each pop.
- States:
  - IDLE: req=0. Moves to REQUEST when the FIFO is non-empty, including a push arriving in this same cycle (visible next cycle).
  - REQUEST: req=1; out_valid = start && !empty.
    - start=1 moves to BURST next cycle.
    - A pop in the first granted cycle is legal and counts (zero-latency grant use).
  - BURST: req=1; out_valid = start && !empty.
    - Moves to RELEASE after a pop that makes burst_cnt==MAX_BURSTS, or that empties the FIFO (occupancy 1, no concurrent push).
    - If start falls with neither condition met (preemption), returns to REQUEST; burst_cnt clears; no done.
  - RELEASE: done=1, req=0, out_valid=0 for exactly one cycle; burst_cnt clears.
    - Next state is REQUEST if the FIFO is non-empty, else IDLE.
    - req stays low for this one cycle so the arbiter rotates to other groups.
- start while in IDLE or RELEASE is ignored (no pop).
- done is registered (state-decoded) and never asserts in the same cycle as out_valid.
- burst_cnt saturates at MAX_BURSTS; it can never exceed it because RELEASE is forced.
- MAX_BURSTS=1: every pop goes directly to RELEASE.
- out_ready low while out_valid high: hold out_valid and out_cmd stable; burst_cnt is unchanged.
- Reset mid-burst: FIFO contents are discarded and no done is issued.

Decomposition:
- Shared package arbiter_pkg:
  - req_state_t enum {IDLE, REQUEST, BURST, RELEASE} (2 bits).
  - Group index constants GROUP_A..GROUP_D = 0..3, shared with the arbiter sel encoding.
  - Function for the burst counter width.
- Sub-module cmd_fifo: synchronous FIFO, parameters CMD_W and DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Asynchronous active-low reset.
  - Shared with other back-end queues.

Test Plan:
- Reset then push 1 command, start held high from the first cycle of req:
  - req rises 1 cycle after the push.
  - 1 pop occurs.
  - RELEASE: done=1 for 1 cycle, then IDLE with req=0.
- Push 6 commands, MAX_BURSTS=4, start=1 continuous, out_ready=1:
  - 4 pops on consecutive cycles; done pulses; req low 1 cycle.
  - req high again; next grant issues 2 pops then done.
- Fill FIFO to 8 with in_valid held high:
  - in_ready=0 at occupancy 8.
  - A 9th command with a concurrent pop is not accepted; it is accepted the following cycle.
- In BURST after 2 pops, drop start:
  - Returns to REQUEST; burst_cnt=0; no done.
  - Re-grant allows 4 fresh pops.
- out_ready toggling 1,0,0,1 with start=1:
  - out_cmd is stable across the stalls.
  - burst_cnt goes 1,1,1,2.
  - done only after the 4th accepted pop.
- Assert rst_n=0 asynchronously mid-BURST:
  - Outputs clear before the next clk edge.
  - FIFO is empty, in_ready=1 after release of reset.
